prio_arbiter8: RTL and testbench
================================

Name: prio_arbiter8

Overview:
- Arbitrates one shared resource among 8 requesters, using the same priority convention as the team's 8-to-3 encoders: index 7 is highest.
- Produces a registered one-hot grant, an encoded grant ID and an idle flag.
- The owner keeps the grant while it holds its request, bounded by an optional timeout.
- Supports fixed-priority and round-robin modes; it fronts shared buses and shared encoder/datapath slots.

Parameters:
- HOLD_MAX, 16, maximum consecutive grant cycles before forced re-arbitration; 0 disables the timeout.
- CNT_W, 8, hold counter width; HOLD_MAX must satisfy HOLD_MAX < 2^CNT_W.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- req  input  8  request per requester, level-sensitive; req[i] is held until served.
- rr_en  input  1  0 = fixed priority (7 highest), 1 = round-robin.
- grant  output  8  one-hot grant, registered; all zeros when no owner.
- grant_id  output  3  binary index of the owner; 0 when grant_valid=0.
- grant_valid  output  1  1 while an owner exists (equals OR of grant).
- idle  output  1  1 when grant_valid=0 (equals ~grant_valid).

Behaviour:
- Reset: one clock, synchronous and active-low. When rst_n=0 at a rising edge, all of the following take effect at that edge:
  - grant=0, grant_id=0, grant_valid=0, idle=1.
  - state=IDLE, hold_cnt=0, last_id=0.
  - Reset mid-grant drops the grant at that edge, with no handover.
- States:
  - IDLE: no owner.
  - OWN: one owner; hold_cnt counts the cycles it has held the grant.
- Winner selection (combinational, from current req):
  - Fixed mode: highest set index.
  - RR mode: mask = bits strictly below last_id.
    - If req&mask != 0, winner = highest set index in req&mask.
    - Otherwise winner = highest set index in req (wrap).
    - Net effect: after owner k, the search order is k-1, k-2, …, 0, 7, …, k.
  - rr_en is sampled at every arbitration edge; a change mid-ownership affects only the next arbitration.
- Latency: req sampled at edge N drives grant visible after edge N (1 cycle). There are no combinational paths from req to outputs.
- IDLE:
  - req=0: stay in IDLE.
  - req!=0: grant the winner, last_id=winner, hold_cnt=1, go to OWN.
- OWN, owner index o:
  - Release: req[o]=0 at an edge. Arbitrate the current req in the same edge, so handover has no idle bubble.
    - Winner exists: grant it, hold_cnt=1.
    - No winner: go to IDLE.
  - Timeout: HOLD_MAX!=0, hold_cnt==HOLD_MAX and req[o]=1. Arbitrate among req with bit o cleared.
    - Another requester present: grant the winner, hold_cnt=1.
    - Owner is the only requester: owner keeps the grant, hold_cnt=1.
  - Otherwise: hold, hold_cnt += 1, saturating at 2^CNT_W-1 (relevant only when HOLD_MAX=0).
- last_id is updated only when a new grant is issued, including on re-grant to the same owner.
- A requester dropping req while not granted has no effect. Arbitration ignores non-owner requests until release or timeout, so there is no preemption.
- Invariants:
  - grant is one-hot or zero.
  - grant_id matches grant.
  - grant_valid = ~idle.
  - Reset values hold on every edge while rst_n=0.

Decomposition:
- Shared Verilog header prio_arb_defs.vh:
  - state encodings ST_IDLE=1'b0 and ST_OWN=1'b1;
  - NREQ=8, ID_W=3.
- One natural sub-module: prio_enc8_v, a combinational 8-to-3 priority encoder with a valid output.
  - Instantiated twice, once for the masked request and once for the unmasked request.
  - The exclude-owner vector for timeout is formed by masking before the encoders.

Test Plan:
- Reset/basic: rst_n=0 for 2 cycles with req=8'hFF → grant=0, idle=1. Release reset, req=8'b0010_0100, rr_en=0 → after 1 edge grant=8'h20, grant_id=5, grant_valid=1.
- Fixed-priority handover: owner 5, req becomes 8'b1000_0100 (5 drops, 7 rises) → next edge grant=8'h80, grant_id=7, no idle cycle. Then req=0 → next edge idle=1, grant_id=0.
- Round-robin rotation: rr_en=1, req held at 8'hFF, each owner drops for 1 cycle then reasserts → grant_id sequence 7,6,5,4,3,2,1,0,7.
- Timeout: HOLD_MAX=4, owner 2 holds req, req[6]=1.
  - Owner 2 holds grant for exactly 4 cycles, then grant=8'h40.
  - Repeat with only req[2] set → grant stays 8'h04, hold_cnt restarts at 1.
- Reset mid-operation: owner 3 granted, rst_n=0 for 1 cycle while req=8'h08 → grant=0 at that edge; regranted to 3 one edge after rst_n=1.
- Mode switch mid-grant: owner 4 under rr_en=0, set rr_en=1, req=8'b1000_1000, owner drops → winner 3 (below last_id=4), not 7.

Source files
------------

// File: rtl/prio_arbiter8_pkg.sv
// Shared definitions for the 8-way priority / round-robin arbiter.
// Index 7 is the highest priority, matching the 8-to-3 encoders.
package prio_arbiter8_pkg;

    localparam int unsigned NREQ = 8;
    localparam int unsigned ID_W = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    // Bits strictly below id; these are the round-robin search set after owner id.
    function automatic logic [NREQ-1:0] below_mask(input logic [ID_W-1:0] id);
        logic [NREQ-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (i < 32'(id)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/prio_arbiter8_enc.sv
// Combinational 8-to-3 priority encoder: highest set index wins, valid = any bit set.
module prio_enc8_v
    import prio_arbiter8_pkg::*;
(
    input  logic [NREQ-1:0] in_vec,
    output logic [ID_W-1:0] id,
    output logic            valid
);

    always_comb begin
        id = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (in_vec[i]) begin
                id = ID_W'(i);
            end
        end
    end

    assign valid = |in_vec;

endmodule

// File: rtl/prio_arbiter8.sv
// 8-requester arbiter with registered one-hot grant, fixed or round-robin selection,
// hold-while-requesting ownership and an optional hold timeout.
module prio_arbiter8
    import prio_arbiter8_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            rr_en,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_id,
    output logic            grant_valid,
    output logic            idle
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [ID_W-1:0]   last_id_q, last_id_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic              grant_valid_q, grant_valid_d;
    logic              idle_q, idle_d;

    logic              owner_req;
    logic              timeout;
    logic [NREQ-1:0]   arb_req;
    logic [NREQ-1:0]   rr_mask;
    logic [ID_W-1:0]   m_id, u_id;
    logic              m_valid, u_valid;
    logic [ID_W-1:0]   win_id;
    logic              win_valid;

    assign owner_req = (state_q == ST_OWN) && req[grant_id_q];
    assign timeout   = (HOLD_MAX != 0) && owner_req
                       && (hold_cnt_q == CNT_W'(HOLD_MAX));

    // On timeout the owner is excluded before encoding; grant_q is its one-hot.
    assign arb_req = timeout ? (req & ~grant_q) : req;
    assign rr_mask = rr_en ? below_mask(last_id_q) : '0;

    prio_enc8_v u_enc_masked (
        .in_vec (arb_req & rr_mask),
        .id     (m_id),
        .valid  (m_valid)
    );

    prio_enc8_v u_enc_full (
        .in_vec (arb_req),
        .id     (u_id),
        .valid  (u_valid)
    );

    assign win_id    = m_valid ? m_id : u_id;
    assign win_valid = u_valid;

    always_comb begin
        logic            do_arb;
        logic            new_valid;
        logic [ID_W-1:0] new_id;

        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        last_id_d  = last_id_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        do_arb     = 1'b0;

        case (state_q)
            ST_IDLE: do_arb = |req;
            ST_OWN: begin
                if (!owner_req || timeout) begin
                    do_arb = 1'b1;
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: do_arb = 1'b1;
        endcase

        // A timed-out owner with no competitor is simply re-granted.
        new_valid = win_valid || timeout;
        new_id    = win_valid ? win_id : grant_id_q;

        if (do_arb) begin
            if (new_valid) begin
                state_d         = ST_OWN;
                hold_cnt_d      = CNT_W'(1);
                last_id_d       = new_id;
                grant_id_d      = new_id;
                grant_d         = '0;
                grant_d[new_id] = 1'b1;
            end else begin
                state_d    = ST_IDLE;
                hold_cnt_d = '0;
                grant_id_d = '0;
                grant_d    = '0;
            end
        end

        grant_valid_d = (state_d == ST_OWN);
        idle_d        = (state_d != ST_OWN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            hold_cnt_q    <= '0;
            last_id_q     <= '0;
            grant_q       <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            idle_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            last_id_q     <= last_id_d;
            grant_q       <= grant_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            idle_q        <= idle_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign grant_valid = grant_valid_q;
    assign idle        = idle_q;

endmodule

// File: tb/tb_prio_arbiter8.sv
// Self-checking bench for prio_arbiter8 (HOLD_MAX=4): expected outputs are queued
// as each cycle of stimulus is driven and compared one edge later.
module tb_prio_arbiter8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic       rr_en;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       grant_valid;
    logic       idle;

    logic [12:0] sb_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    prio_arbiter8 #(.HOLD_MAX(4), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .rr_en       (rr_en),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .idle        (idle)
    );

    function automatic logic [12:0] exp_outs(input logic [7:0] g);
        logic [2:0] id;
        id = '0;
        for (int i = 0; i < 8; i++) begin
            if (g[i]) id = 3'(i);
        end
        return {g, id, |g, ~|g};
    endfunction

    // Drive one cycle of stimulus, queue its expected result, land #1 after the edge.
    task automatic apply(input logic [7:0] r, input logic rr, input logic rst,
                         input logic [7:0] g);
        @(negedge clk);
        req   = r;
        rr_en = rr;
        rst_n = rst;
        sb_q.push_back(exp_outs(g));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] r_t[3] = '{8'hFF, 8'hFF, 8'h24};
        logic       s_t[3] = '{1'b0, 1'b0, 1'b1};
        logic [7:0] g_t[3] = '{8'h00, 8'h00, 8'h20};
        logic [12:0] exp, got;
        for (int i = 0; i < 3; i++) begin
            apply(r_t[i], 1'b0, s_t[i], g_t[i]);
            exp = sb_q.pop_front();
            got = {grant, grant_id, grant_valid, idle};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_basic step %0d: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_fixed_handover();
        logic [7:0] r_t[5] = '{8'h00, 8'h24, 8'hA4, 8'h84, 8'h00};
        logic       s_t[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [7:0] g_t[5] = '{8'h00, 8'h20, 8'h20, 8'h80, 8'h00};
        logic [12:0] exp, got;
        for (int i = 0; i < 5; i++) begin
            apply(r_t[i], 1'b0, s_t[i], g_t[i]);
            exp = sb_q.pop_front();
            got = {grant, grant_id, grant_valid, idle};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL fixed_handover step %0d: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_rr_rotation();
        logic [12:0] exp, got;
        logic [7:0]  drop;
        int          nxt;
        apply(8'h00, 1'b1, 1'b0, 8'h00);
        exp = sb_q.pop_front();
        got = {grant, grant_id, grant_valid, idle};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL rr_reset: got %h expected %h", got, exp);
        end
        apply(8'hFF, 1'b1, 1'b1, 8'h80);
        exp = sb_q.pop_front();
        got = {grant, grant_id, grant_valid, idle};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL rr_first: got %h expected %h", got, exp);
        end
        for (int k = 7; k >= 0; k--) begin
            nxt  = (k == 0) ? 7 : k - 1;
            drop = 8'hFF;
            drop[k] = 1'b0;
            apply(drop, 1'b1, 1'b1, 8'(1) << nxt);
            exp = sb_q.pop_front();
            got = {grant, grant_id, grant_valid, idle};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL rr_rotate drop %0d: got %h expected %h", k, got, exp);
            end
            apply(8'hFF, 1'b1, 1'b1, 8'(1) << nxt);
            exp = sb_q.pop_front();
            got = {grant, grant_id, grant_valid, idle};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL rr_hold owner %0d: got %h expected %h", nxt, got, exp);
            end
        end
    endtask

    task automatic test_timeout();
        logic [7:0] r_t[7] = '{8'h00, 8'h04, 8'h44, 8'h44, 8'h44, 8'h44, 8'h44};
        logic       s_t[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [7:0] g_t[7] = '{8'h00, 8'h04, 8'h04, 8'h04, 8'h04, 8'h40, 8'h40};
        logic [12:0] exp, got;
        for (int i = 0; i < 7; i++) begin
            apply(r_t[i], 1'b0, s_t[i], g_t[i]);
            exp = sb_q.pop_front();
            got = {grant, grant_id, grant_valid, idle};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL timeout_handover step %0d: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_timeout_regrant();
        logic [7:0] r_t[10] = '{8'h00, 8'h04, 8'h04, 8'h04, 8'h04, 8'h04,
                                8'h44, 8'h44, 8'h44, 8'h44};
        logic       s_t[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                1'b1, 1'b1, 1'b1, 1'b1};
        logic [7:0] g_t[10] = '{8'h00, 8'h04, 8'h04, 8'h04, 8'h04, 8'h04,
                                8'h04, 8'h04, 8'h04, 8'h40};
        logic [12:0] exp, got;
        for (int i = 0; i < 10; i++) begin
            apply(r_t[i], 1'b0, s_t[i], g_t[i]);
            exp = sb_q.pop_front();
            got = {grant, grant_id, grant_valid, idle};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL timeout_regrant step %0d: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        logic [7:0] r_t[4] = '{8'h00, 8'h08, 8'h08, 8'h08};
        logic       s_t[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] g_t[4] = '{8'h00, 8'h08, 8'h00, 8'h08};
        logic [12:0] exp, got;
        for (int i = 0; i < 4; i++) begin
            apply(r_t[i], 1'b0, s_t[i], g_t[i]);
            exp = sb_q.pop_front();
            got = {grant, grant_id, grant_valid, idle};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset_mid_grant step %0d: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_mode_switch();
        logic [7:0] r_t[4]  = '{8'h00, 8'h10, 8'h88, 8'h80};
        logic       rr_t[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic       s_t[4]  = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [7:0] g_t[4]  = '{8'h00, 8'h10, 8'h08, 8'h80};
        logic [12:0] exp, got;
        for (int i = 0; i < 4; i++) begin
            apply(r_t[i], rr_t[i], s_t[i], g_t[i]);
            exp = sb_q.pop_front();
            got = {grant, grant_id, grant_valid, idle};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL mode_switch step %0d: got %h expected %h", i, got, exp);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req   = 8'hFF;
        rr_en = 1'b0;
        test_reset();
        test_fixed_handover();
        test_rr_rotation();
        test_timeout();
        test_timeout_regrant();
        test_reset_mid_grant();
        test_mode_switch();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
